// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC-tile array sequencer:
// state encoding, west-edge instruction codes and phase-length helpers.
package mac_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Cycles for the last kernel word to reach the far column.
  function automatic int settle_len(input int col);
    return col + 1;
  endfunction

  // Cycles for the psum/activation wavefront to leave the array.
  function automatic int drain_len(input int row, input int col);
    return row + col;
  endfunction

endpackage

// File: rtl/mac_ctrl_phase_cnt.sv
// Loadable down-counter with a terminal-count flag; one instance times
// every fixed- or variable-length phase of the sequencer.
module mac_ctrl_phase_cnt #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/mac_array_ctrl.sv
// Job sequencer for a weight-stationary MAC-tile array: clear, kernel load,
// settle, activation stream, drain, done.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int ROW     = 8,
  parameter int COL     = 8,
  parameter int ADDR_BW = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_BW-1:0] num_act,
  input  logic [ADDR_BW-1:0] w_base,
  input  logic [ADDR_BW-1:0] x_base,
  output logic               array_rst,
  output logic [1:0]         inst_w,
  output logic               w_ren,
  output logic [ADDR_BW-1:0] w_addr,
  output logic               x_ren,
  output logic [ADDR_BW-1:0] x_addr,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_o
);

  state_t             state_reg, state_next;
  logic [ADDR_BW-1:0] num_act_reg, w_base_reg, x_base_reg;
  logic [ADDR_BW-1:0] idx_reg;
  logic [ADDR_BW-1:0] cnt_val;
  logic               cnt_load, cnt_tc;
  logic [1:0]         inst_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      num_act_reg <= '0;
      w_base_reg  <= '0;
      x_base_reg  <= '0;
    end else if (state_reg == ST_IDLE && start) begin
      num_act_reg <= num_act;
      w_base_reg  <= w_base;
      x_base_reg  <= x_base;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start)  state_next = ST_CLEAR;
      ST_CLEAR:              state_next = ST_LOAD;
      ST_LOAD:   if (cnt_tc) state_next = ST_SETTLE;
      ST_SETTLE: if (cnt_tc) state_next = (num_act_reg == '0) ? ST_DRAIN : ST_EXEC;
      ST_EXEC:   if (cnt_tc) state_next = ST_DRAIN;
      ST_DRAIN:  if (cnt_tc) state_next = ST_DONE;
      ST_DONE:               state_next = ST_IDLE;
      default:               state_next = ST_IDLE;
    endcase
  end

  // The phase counter is armed with (length-1) on every state change.
  always_comb begin
    cnt_load = (state_next != state_reg);
    cnt_val  = '0;
    case (state_next)
      ST_LOAD:   cnt_val = ADDR_BW'(COL - 1);
      ST_SETTLE: cnt_val = ADDR_BW'(settle_len(COL) - 1);
      ST_EXEC:   cnt_val = num_act_reg - 1'b1;
      ST_DRAIN:  cnt_val = ADDR_BW'(drain_len(ROW, COL) - 1);
      default:   cnt_val = '0;
    endcase
  end

  mac_ctrl_phase_cnt #(
    .W(ADDR_BW)
  ) u_phase_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .tc       (cnt_tc)
  );

  // Offset within the current phase; wraps naturally at 2^ADDR_BW.
  always_ff @(posedge clk) begin
    if (reset || cnt_load) idx_reg <= '0;
    else                   idx_reg <= idx_reg + 1'b1;
  end

  always_comb begin
    array_rst = 1'b0;
    w_ren     = 1'b0;
    w_addr    = '0;
    x_ren     = 1'b0;
    x_addr    = '0;
    done      = 1'b0;
    busy      = (state_reg != ST_IDLE);
    case (state_reg)
      ST_CLEAR: array_rst = 1'b1;
      ST_LOAD: begin
        w_ren  = 1'b1;
        w_addr = w_base_reg + idx_reg;
      end
      ST_EXEC: begin
        x_ren  = 1'b1;
        x_addr = x_base_reg + idx_reg;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // SRAM data arrives one cycle after the read, so the instruction lags it.
  always_ff @(posedge clk) begin
    if (reset)      inst_reg <= INST_IDLE;
    else if (w_ren) inst_reg <= INST_LOAD;
    else if (x_ren) inst_reg <= INST_EXEC;
    else            inst_reg <= INST_IDLE;
  end

  assign inst_w  = inst_reg;
  assign state_o = state_reg;

endmodule
